// File: rtl/gpio_axil_pkg.sv
// Shared definitions for the GPIO AXI4-Lite responder: register offsets,
// response codes, channel FSM state types and the byte-strobe helper.
package gpio_axil_pkg;

    localparam logic [4:0] ADDR_GPIO_OUT   = 5'h00;
    localparam logic [4:0] ADDR_GPIO_DIR   = 5'h04;
    localparam logic [4:0] ADDR_IRQ_MASK   = 5'h08;
    localparam logic [4:0] ADDR_SCRATCH    = 5'h0C;
    localparam logic [4:0] ADDR_GPIO_IN    = 5'h10;
    localparam logic [4:0] ADDR_IRQ_STATUS = 5'h14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Expands a 4-bit byte strobe into a 32-bit bit mask.
    function automatic logic [31:0] strobe_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for asynchronous GPIO pin inputs; synchronous
// active-high reset clears both stages.
module gpio_sync2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs before either updates, giving a true 2-flop chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gpio_axil_slave.sv
// AXI4-Lite responder driving a small GPIO register file.
// Optional macro GPIO_IRQ_EN adds the rising-edge IRQ_STATUS register and irq.
module gpio_axil_slave
    import gpio_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int GPIO_WIDTH         = 32
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [GPIO_WIDTH-1:0]           gpio_i,
    output logic [GPIO_WIDTH-1:0]           gpio_o,
    output logic [GPIO_WIDTH-1:0]           gpio_oe,
    output logic                            irq
);

    localparam logic [31:0] GPIO_MASK = (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                      : ((32'd1 << GPIO_WIDTH) - 32'd1);

    w_state_t        w_state;
    r_state_t        r_state;
    logic            aw_done, w_done;
    logic [2:0]      aw_idx;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic [31:0]     gpio_out, gpio_dir, irq_mask, scratch;
    logic [GPIO_WIDTH-1:0] gpio_in_sync;
    logic [31:0]     gpio_in_ext;
    logic [4:0]      wr_addr;
    logic [31:0]     wr_mask;
    logic [1:0]      wr_resp;
    logic            wr_commit;
    logic [31:0]     rd_data;
    logic [1:0]      rd_resp;
    logic            aw_hs, w_hs, ar_hs;
    logic            unused_addr_bits;

    assign unused_addr_bits = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    gpio_sync2 #(.WIDTH(GPIO_WIDTH)) u_sync (
        .clk (ACLK),
        .rst (ARESET),
        .d   (gpio_i),
        .q   (gpio_in_sync)
    );

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign wr_commit = aw_done && w_done;
    assign wr_addr   = {aw_idx, 2'b00};
    assign wr_mask   = strobe_mask(wstrb_q);

    function automatic logic [1:0] resp_for(input logic [4:0] addr);
        case (addr)
            ADDR_GPIO_OUT, ADDR_GPIO_DIR, ADDR_IRQ_MASK,
            ADDR_SCRATCH, ADDR_GPIO_IN: return RESP_OKAY;
`ifdef GPIO_IRQ_EN
            ADDR_IRQ_STATUS:            return RESP_OKAY;
`endif
            default:                    return RESP_SLVERR;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_val);
        return (old_val & ~wr_mask) | (wdata_q & wr_mask);
    endfunction

    assign wr_resp = resp_for(wr_addr);

`ifdef GPIO_IRQ_EN
    logic [31:0] irq_status, sync_prev, irq_clear;

    assign irq_clear = (wr_commit && wr_addr == ADDR_IRQ_STATUS) ? (wdata_q & wr_mask) : '0;

    // Set is OR-ed in after the clear so a simultaneous rising edge wins.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync_prev  <= '0;
            irq_status <= '0;
            irq        <= 1'b0;
        end else begin
            sync_prev  <= gpio_in_ext;
            irq_status <= (irq_status & ~irq_clear) | (gpio_in_ext & ~sync_prev);
            irq        <= |(irq_status & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gpio_in_ext                 = '0;
        gpio_in_ext[GPIO_WIDTH-1:0] = gpio_in_sync;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = resp_for({S_AXI_ARADDR[4:2], 2'b00});
        case ({S_AXI_ARADDR[4:2], 2'b00})
            ADDR_GPIO_OUT:   rd_data = gpio_out;
            ADDR_GPIO_DIR:   rd_data = gpio_dir;
            ADDR_IRQ_MASK:   rd_data = irq_mask;
            ADDR_SCRATCH:    rd_data = scratch;
            ADDR_GPIO_IN:    rd_data = gpio_in_ext;
`ifdef GPIO_IRQ_EN
            ADDR_IRQ_STATUS: rd_data = irq_status;
`endif
            default:         rd_data = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gpio_out <= '0;
            gpio_dir <= '0;
            irq_mask <= '0;
            scratch  <= '0;
            gpio_o   <= '0;
            gpio_oe  <= '0;
        end else begin
            if (wr_commit) begin
                case (wr_addr)
                    ADDR_GPIO_OUT: gpio_out <= merge(gpio_out) & GPIO_MASK;
                    ADDR_GPIO_DIR: gpio_dir <= merge(gpio_dir) & GPIO_MASK;
                    ADDR_IRQ_MASK: irq_mask <= merge(irq_mask) & GPIO_MASK;
                    ADDR_SCRATCH:  scratch  <= merge(scratch);
                    default:       ;
                endcase
            end
            gpio_o  <= gpio_out[GPIO_WIDTH-1:0];
            gpio_oe <= gpio_dir[GPIO_WIDTH-1:0];
        end
    end

    // Write channel: AW and W latch independently; the commit happens on the
    // edge after both are held, and BVALID rises on that same edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state       <= W_IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            aw_idx        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE, W_WAIT: begin
                    if (aw_hs) begin
                        aw_idx  <= S_AXI_AWADDR[4:2];
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        w_done  <= 1'b1;
                    end
                    S_AXI_AWREADY <= !(aw_done || aw_hs);
                    S_AXI_WREADY  <= !(w_done || w_hs);
                    if (wr_commit) begin
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        S_AXI_BVALID <= 1'b1;
                        S_AXI_BRESP  <= wr_resp;
                        w_state      <= W_RESP;
                    end else if (aw_hs || w_hs || aw_done || w_done) begin
                        w_state <= W_WAIT;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    S_AXI_ARREADY <= !ar_hs;
                    if (ar_hs) begin
                        S_AXI_RDATA  <= rd_data;
                        S_AXI_RRESP  <= rd_resp;
                        S_AXI_RVALID <= 1'b1;
                        r_state      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_axil_slave.sv
// Self-checking bench for gpio_axil_slave: directed register tests, handshake
// timing, reset, and a randomized phase against a behavioural register model.
module tb_gpio_axil_slave;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic [31:0] gpio_i = '0;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe;
    logic        irq;

    always #5 ACLK = ~ACLK;

    gpio_axil_slave dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .gpio_i        (gpio_i),
        .gpio_o        (gpio_o),
        .gpio_oe       (gpio_oe),
        .irq           (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the register file as seen from the bus.
    logic [31:0] m_out, m_dir, m_mask, m_scratch, m_status, m_pins;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic exp_irq();
`ifdef GPIO_IRQ_EN
        return |(m_status & m_mask);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_out = '0; m_dir = '0; m_mask = '0; m_scratch = '0;
        m_status = m_pins;  // synchroniser restarts from 0, so high pins look like rising edges
    endtask

    task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] r);
        r = OKAY;
        case (a)
            5'h00: m_out     = byte_merge(m_out, d, s);
            5'h04: m_dir     = byte_merge(m_dir, d, s);
            5'h08: m_mask    = byte_merge(m_mask, d, s);
            5'h0C: m_scratch = byte_merge(m_scratch, d, s);
            5'h10: r = OKAY;
`ifdef GPIO_IRQ_EN
            5'h14: m_status = m_status & ~(byte_merge(32'h0, d, s));
`endif
            default: r = SLVERR;
        endcase
    endtask

    task automatic model_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        r = OKAY;
        d = '0;
        case (a)
            5'h00: d = m_out;
            5'h04: d = m_dir;
            5'h08: d = m_mask;
            5'h0C: d = m_scratch;
            5'h10: d = m_pins;
`ifdef GPIO_IRQ_EN
            5'h14: d = m_status;
`endif
            default: r = SLVERR;
        endcase
    endtask

    // Called and returns at a falling edge; pins then settle for 'settle' edges.
    task automatic set_pins(input logic [31:0] v, input int settle);
        gpio_i = v;
        m_status = m_status | (v & ~m_pins);
        m_pins = v;
        repeat (settle) @(negedge ACLK);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp);
        int   cyc;
        bit   aw_ok, w_ok, aw_hs, w_hs;
        logic [1:0] first;
        cyc = 0; aw_ok = 0; w_ok = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(aw_ok && w_ok) && cyc < 50) begin
            S_AXI_AWVALID = !aw_ok && (cyc >= aw_dly);
            S_AXI_WVALID  = !w_ok && (cyc >= w_dly);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            if (aw_ok && !w_ok) check("awready_low_while_w_pending", S_AXI_AWREADY, 0);
            @(negedge ACLK);
            aw_ok = aw_ok | aw_hs;
            w_ok  = w_ok | w_hs;
            cyc++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {aw_ok, w_ok}, 2'b11);
        cyc = 0;
        while (!S_AXI_BVALID && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        check("bvalid_arrives", S_AXI_BVALID, 1);
        first = S_AXI_BRESP;
        for (int i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            check("bvalid_held", S_AXI_BVALID, 1);
            check("bresp_stable", S_AXI_BRESP, first);
            check("awready_low_during_b", S_AXI_AWREADY, 0);
        end
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        check("bvalid_drops", S_AXI_BVALID, 0);
        check("readies_after_b", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        resp = first;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        int cyc;
        cyc = 0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!S_AXI_ARREADY && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        check("arready_seen", S_AXI_ARREADY, 1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("rvalid_one_cycle_latency", S_AXI_RVALID, 1);
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
        check("rvalid_drops", S_AXI_RVALID, 0);
    endtask

    task automatic wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] er, r;
        model_write(a, d, s, er);
        axi_write(a, d, s, 0, 0, 0, r);
        check({tag, "_bresp"}, r, er);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, output logic [31:0] d);
        logic [31:0] ed;
        logic [1:0]  er, r;
        model_read(a, ed, er);
        axi_read(a, d, r);
        check({tag, "_rdata"}, d, ed);
        check({tag, "_rresp"}, r, er);
    endtask

    task automatic check_pins(input string tag);
        check({tag, "_gpio_o"}, gpio_o, m_out);
        check({tag, "_gpio_oe"}, gpio_oe, m_dir);
        check({tag, "_irq"}, irq, exp_irq());
    endtask

    initial begin
        logic [31:0] d, rd;
        logic [1:0]  r, er;
        logic [4:0]  a;
        logic [3:0]  s;
        m_pins = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge ACLK);
        check("reset_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        check("reset_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("reset_rdata", S_AXI_RDATA, 0);
        check_pins("reset");
        ARESET = 1'b0;
        @(negedge ACLK);
        check("idle_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Basic RW registers
        wr("w_out", 5'h00, 32'h1, 4'hF);
        wr("w_dir", 5'h04, 32'h2, 4'hF);
        wr("w_mask", 5'h08, 32'h3, 4'hF);
        wr("w_scr", 5'h0C, 32'h4, 4'hF);
        rd_check("r_out", 5'h00, rd);
        rd_check("r_dir", 5'h04, rd);
        rd_check("r_mask", 5'h08, rd);
        rd_check("r_scr", 5'h0C, rd);
        check("gpio_o_basic", gpio_o, 32'h1);
        check("gpio_oe_basic", gpio_oe, 32'h2);

        // Byte strobes
        wr("w_scr_clr", 5'h0C, 32'h0, 4'hF);
        wr("w_scr_strb", 5'h0C, 32'hAABB_CCDD, 4'b0101);
        rd_check("r_scr_strb", 5'h0C, rd);
        check("strobe_value", rd, 32'h00BB_00DD);
        wr("w_scr_nostrb", 5'h0C, 32'hFFFF_FFFF, 4'b0000);
        rd_check("r_scr_nostrb", 5'h0C, rd);

        // AW three cycles ahead of W, BREADY held low four cycles
        model_write(5'h0C, 32'h1234_5678, 4'hF, er);
        axi_write(5'h0C, 32'h1234_5678, 4'hF, 0, 3, 4, r);
        check("aw_early_bresp", r, er);
        rd_check("aw_early_readback", 5'h0C, rd);

        // GPIO input path
        set_pins(32'h5A5A_5A5A, 3);
        rd_check("gpio_in", 5'h10, rd);
        check("gpio_in_value", rd, 32'h5A5A_5A5A);
        wr("w_gpio_in", 5'h10, 32'hDEAD_BEEF, 4'hF);
        rd_check("gpio_in_after_write", 5'h10, rd);

        // Unmapped and optional register
        wr("w_unmapped18", 5'h18, 32'hFFFF_FFFF, 4'hF);
        rd_check("r_unmapped18", 5'h18, rd);
        rd_check("r_unmapped1c", 5'h1C, rd);
        rd_check("r_status", 5'h14, rd);

        // Interrupt path
        wr("w_status_clr_all", 5'h14, 32'hFFFF_FFFF, 4'hF);
        wr("w_mask_bit0", 5'h08, 32'h1, 4'hF);
        set_pins(32'h0, 5);
        check_pins("irq_idle");
        set_pins(32'h1, 5);
        check_pins("irq_rise");
        rd_check("r_status_rise", 5'h14, rd);
        wr("w_status_clr0", 5'h14, 32'h1, 4'hF);
        check_pins("irq_cleared");

        // Randomized traffic against the model
        set_pins($urandom, 5);
        for (int i = 0; i < 60; i++) begin
            a = 5'($urandom_range(0, 7) * 4);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wr("rand_w", a, d, s);
                check_pins("rand_w");
            end else begin
                rd_check("rand_r", a, rd);
            end
        end

        // Reset in the middle of a read
        set_pins(32'h0, 5);
        S_AXI_ARADDR  = 5'h00;
        S_AXI_ARVALID = 1'b1;
        check("mid_arready", S_AXI_ARREADY, 1);
        @(negedge ACLK);
        S_AXI_ARVALID = 1'b0;
        check("mid_rvalid", S_AXI_RVALID, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        check("mid_reset_rvalid", S_AXI_RVALID, 0);
        check("mid_reset_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        ARESET = 1'b0;
        model_reset();
        @(negedge ACLK);
        check_pins("mid_reset");
        rd_check("post_reset_out", 5'h00, rd);
        rd_check("post_reset_dir", 5'h04, rd);
        rd_check("post_reset_mask", 5'h08, rd);
        rd_check("post_reset_scr", 5'h0C, rd);
        rd_check("post_reset_status", 5'h14, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpio_axil_slave.md
Name: gpio_axil_slave

Overview:
- AXI4-Lite responder (slave) for the GPIO control IP; the far end of the AXI4-Lite master used by the block-design bench.
- Decodes single-beat AXI4-Lite reads and writes into a small GPIO register file.
- Drives the GPIO output and output-enable pins and samples the GPIO input pins through a 2-flop synchroniser.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, bus data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decode uses bits [4:2].
- GPIO_WIDTH, 32, number of GPIO pins; 1..32; register bits above GPIO_WIDTH read 0.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWVALID/AWREADY  in/out  1  write address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID/WREADY  in/out  1  write data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID/BREADY  out/in  1  write response handshake
- S_AXI_ARADDR  in  5  read address
- S_AXI_ARVALID/ARREADY  in/out  1  read address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID/RREADY  out/in  1  read data handshake
- gpio_i  in  GPIO_WIDTH  asynchronous pin inputs
- gpio_o  out  GPIO_WIDTH  pin output values (GPIO_OUT)
- gpio_oe  out  GPIO_WIDTH  output enables (GPIO_DIR; 1 = drive)
- irq  out  1  level interrupt

Behaviour:
- Address map:
  - 0x00 GPIO_OUT, RW.
  - 0x04 GPIO_DIR, RW.
  - 0x08 IRQ_MASK, RW.
  - 0x0C SCRATCH, RW.
  - 0x10 GPIO_IN, RO; writes ignored, BRESP OKAY.
  - 0x14 IRQ_STATUS, W1C (see Optional Feature).
  - 0x18 and 0x1C unmapped: SLVERR; reads return 0.
- Reset (ARESET high at ACLK edge): all registers 0; AWREADY, WREADY, ARREADY, BVALID and RVALID 0; BRESP, RRESP and RDATA 0; sync flops 0. Applies mid-transaction: any in-flight handshake is abandoned and the next cycle is idle.
- Write FSM states: W_IDLE, W_WAIT, W_RESP.
  - W_IDLE: AWREADY=1 and WREADY=1.
  - An AW or W handshake latches that channel; the satisfied channel's READY drops.
  - When both channels are latched (same cycle or up to any number of cycles apart), the write commits on the next edge and the FSM enters W_RESP with BVALID=1.
  - BVALID holds, with BRESP stable, until BREADY. Then the FSM returns to W_IDLE, with both READYs high again on the following cycle.
  - WSTRB[n] gates byte n of the commit. WSTRB=0 commits nothing but still returns a response.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1.
  - An AR handshake registers RDATA/RRESP, and RVALID=1 on the next cycle (1-cycle latency).
  - RVALID and RDATA hold until RREADY. Then ARREADY=1 on the following cycle.
  - Back-to-back read throughput is therefore one read per 2 cycles minimum.
- Read and write channels are independent. If a write commit and a read capture hit the same register on the same edge, the read returns the pre-write value.
- GPIO_IN = 2-flop synchronised gpio_i, so the register reflects a pin change 2 edges later (read-visible at 3rd).
- gpio_o and gpio_oe are registered copies of GPIO_OUT and GPIO_DIR; they update on the edge after the write commit.

Optional Feature:
- Macro GPIO_IRQ_EN.
- Defined:
  - A rising edge on synchronised GPIO_IN bit n sets IRQ_STATUS[n].
  - Writing 1 to IRQ_STATUS[n] clears it. When a set and a clear hit the same bit in the same cycle, set wins.
  - irq = |(IRQ_STATUS & IRQ_MASK), registered.
- Undefined: IRQ_STATUS logic is absent; 0x14 decodes as unmapped (SLVERR, reads 0); irq tied 0.

Decomposition:
- Package gpio_axil_pkg holds:
  - register offset localparams (ADDR_GPIO_OUT through ADDR_IRQ_STATUS);
  - RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10;
  - the write-FSM and read-FSM state enums.
- One sub-module: gpio_sync2, a parameterised-width 2-flop synchroniser with synchronous active-high reset.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08 and 0x0C, then read back → 0x1, 0x2, 0x3, 0x4, RRESP OKAY; gpio_o=0x1, gpio_oe=0x2.
- Write 0xAABBCCDD to 0x0C with WSTRB=4'b0101 over a prior value of 0 → readback 0x00BB00DD.
- AWVALID 3 cycles before WVALID, BREADY held low 4 cycles → single commit; BVALID held 4+ cycles with BRESP stable; AWREADY stays low until BVALID is accepted.
- gpio_i driven to 0x5A5A5A5A → read of 0x10 returns 0x5A5A5A5A on reads issued ≥3 cycles later; a write to 0x10 returns OKAY with no change.
- Access to 0x18 → BRESP SLVERR; read returns 0 with RRESP SLVERR. Assert ARESET mid-read (RVALID=1) → RVALID=0 next cycle and all registers 0.
- With GPIO_IRQ_EN: IRQ_MASK=0x1, gpio_i[0] rises → irq=1, IRQ_STATUS=0x1; write 0x1 to 0x14 → irq=0. Without GPIO_IRQ_EN: read of 0x14 returns SLVERR and irq stays 0.
